// File: rtl/sync_split_pkg.sv
// sync_split_pkg: shared interconnect field layout and FSM states for sync_split.
// Request is {valid, addr, wdata, wstrb}, response is {rdata, ready}, LSB-first per slot i.
`ifndef SYNC_SPLIT_PKG_SV
`define SYNC_SPLIT_PKG_SV
`define IC_REQ_W(A, D) (1 + (A) + (D) + (D) / 8)
`define IC_RESP_W(D) ((D) + 1)
`define IC_REQ(i, A, D) ((i) * `IC_REQ_W(A, D))
`define IC_WSTRB(i, A, D) (`IC_REQ(i, A, D))
`define IC_WDATA(i, A, D) (`IC_WSTRB(i, A, D) + (D) / 8)
`define IC_ADDR(i, A, D) (`IC_WDATA(i, A, D) + (D))
`define IC_VALID(i, A, D) (`IC_ADDR(i, A, D) + (A))
`define IC_RESP(i, D) ((i) * `IC_RESP_W(D))
`define IC_READY(i, D) (`IC_RESP(i, D))
`define IC_RDATA(i, D) (`IC_RESP(i, D) + 1)

package sync_split_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;
endpackage
`endif

// File: rtl/sync_split.sv
// sync_split: address-decoded single-master to N-slave demux with transaction-locked response routing.
// Define SYNC_SPLIT_ERR_EN to answer unmapped selects internally and flag them on err_o.
module sync_split
    import sync_split_pkg::*;
#(
    parameter int N_SLAVES = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic [`IC_REQ_W(ADDR_W, DATA_W)-1:0] m_req,
    output logic [`IC_RESP_W(DATA_W)-1:0] m_resp,
    output logic [N_SLAVES*`IC_REQ_W(ADDR_W, DATA_W)-1:0] s_req,
    input  logic [N_SLAVES*`IC_RESP_W(DATA_W)-1:0] s_resp
`ifdef SYNC_SPLIT_ERR_EN
    ,
    output logic err_o
`endif
);
    localparam int SEL_W = $clog2(N_SLAVES);
    localparam int REQ_W = `IC_REQ_W(ADDR_W, DATA_W);
    localparam int RESP_W = `IC_RESP_W(DATA_W);
    localparam int ADDR_MSB = `IC_ADDR(0, ADDR_W, DATA_W) + ADDR_W - 1;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N_SLAVES - 1);
    localparam logic [SEL_W:0] COUNT = (SEL_W + 1)'(N_SLAVES);

    state_t state, state_n;
    logic [SEL_W-1:0] sel_q, dec_sel, sel;
    logic valid, unmapped, err_sel, route, ready;

    assign valid = m_req[`IC_VALID(0, ADDR_W, DATA_W)];
    assign dec_sel = m_req[ADDR_MSB -: SEL_W];
    assign unmapped = {1'b0, dec_sel} >= COUNT;
    // Clamping keeps the mux index in range; the error build blocks routing instead.
    assign sel = state == BUSY ? sel_q : unmapped ? LAST : dec_sel;
`ifdef SYNC_SPLIT_ERR_EN
    assign err_sel = unmapped;
`else
    assign err_sel = 1'b0;
`endif
    assign route = valid && !rst && (state == BUSY || (state == IDLE && !err_sel));
    assign ready = m_resp[`IC_READY(0, DATA_W)];

    always_comb begin
        s_req = '0;
        m_resp = '0;
        if (route) begin
            s_req[`IC_REQ(sel, ADDR_W, DATA_W) +: REQ_W] = m_req;
            m_resp = s_resp[`IC_RESP(sel, DATA_W) +: RESP_W];
        end
        if (state == ERR && !rst) m_resp = RESP_W'(1);
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (valid) state_n = err_sel ? ERR : ready ? IDLE : BUSY;
            BUSY: if (!valid || ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel_q <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n == BUSY) sel_q <= sel;
        end
    end

`ifdef SYNC_SPLIT_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_o <= 1'b0;
        else if (state_n == ERR) err_o <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_sync_split.sv
// tb_sync_split: randomized and directed checks of sync_split against a transaction-level model.
// Main instance uses N_SLAVES=4; a second N_SLAVES=3 instance covers the unmapped select.
module tb_sync_split;
    localparam int AW = 32, DW = 32, RQ = 1 + AW + DW + DW / 8, RS = DW + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [RQ-1:0] m_req = '0, m_req3 = '0;
    logic [RS-1:0] m_resp, m_resp3;
    logic [4*RQ-1:0] s_req;
    logic [4*RS-1:0] s_resp = '0;
    logic [3*RQ-1:0] s_req3;
    logic [3*RS-1:0] s_resp3 = '0;
`ifdef SYNC_SPLIT_ERR_EN
    logic err4, err3;
`endif

    always #5 clk = ~clk;

    sync_split #(.N_SLAVES(4), .DATA_W(DW), .ADDR_W(AW)) dut4 (
        .clk(clk), .rst(rst), .m_req(m_req), .m_resp(m_resp), .s_req(s_req), .s_resp(s_resp)
`ifdef SYNC_SPLIT_ERR_EN
        , .err_o(err4)
`endif
    );

    sync_split #(.N_SLAVES(3), .DATA_W(DW), .ADDR_W(AW)) dut3 (
        .clk(clk), .rst(rst), .m_req(m_req3), .m_resp(m_resp3), .s_req(s_req3), .s_resp(s_resp3)
`ifdef SYNC_SPLIT_ERR_EN
        , .err_o(err3)
`endif
    );

    int vectors = 0, errs = 0;
    int owner = -1;
    logic [4*RQ-1:0] exp_sreq;
    logic [RS-1:0] exp_resp;

    function automatic logic [RQ-1:0] req(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        return {v, a, d, s};
    endfunction

    // The slave a request talks to: the one owning an open transaction, else the one its address names.
    function automatic int target();
        logic [31:0] a;
        a = m_req[RQ-2 -: 32];
        return owner >= 0 ? owner : int'(a / 32'h4000_0000);
    endfunction

    task automatic model_eval();
        int t;
        t = target();
        exp_sreq = '0;
        exp_resp = '0;
        if (m_req[RQ-1]) begin
            exp_sreq[t*RQ +: RQ] = m_req;
            exp_resp = s_resp[t*RS +: RS];
        end
        if (rst) exp_resp = '0;
    endtask

    task automatic model_commit();
        int t;
        t = target();
        if (rst) owner = -1;
        else if (owner >= 0) begin
            if (!m_req[RQ-1] || s_resp[owner*RS]) owner = -1;
        end else if (m_req[RQ-1] && !s_resp[t*RS]) owner = t;
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        m_req = req(1'b1, 32'h4000_0000, $urandom, 4'hF);
        for (int i = 0; i < 4; i++) s_resp[i*RS +: RS] = {32'($urandom), 1'b1};
        m_req3 = req(1'b1, 32'h0000_0000, 32'h1, 4'h1);
        s_resp3 = {3{32'hFFFF_FFFF, 1'b1}};
        repeat (2) begin
            settle();
            vectors++;
            if (m_resp !== '0) begin errs++; $display("FAIL reset_m_resp got %h exp 0", m_resp); end
            vectors++;
            if (m_resp3 !== '0) begin errs++; $display("FAIL reset_m_resp3 got %h exp 0", m_resp3); end
            advance();
        end
        rst = 1'b0;
        m_req = '0; s_resp = '0; m_req3 = '0; s_resp3 = '0;
        settle();
        vectors++;
        if (s_req !== '0 || m_resp !== '0) begin errs++; $display("FAIL idle_zero s_req %h m_resp %h exp 0", s_req, m_resp); end
        advance();
    endtask

    task automatic test_zero_wait();
        m_req = req(1'b1, 32'h8000_0010, 32'hCAFE_BABE, 4'hF);
        for (int i = 0; i < 4; i++) s_resp[i*RS +: RS] = {32'hD00D_0000 | 32'(i), 1'b1};
        settle();
        vectors++;
        if (s_req !== exp_sreq) begin errs++; $display("FAIL zero_wait_s_req got %h exp %h", s_req, exp_sreq); end
        vectors++;
        if (s_req[2*RQ +: RQ] !== {1'b1, 32'h8000_0010, 32'hCAFE_BABE, 4'hF}) begin errs++; $display("FAIL zero_wait_slice2 got %h", s_req[2*RQ +: RQ]); end
        vectors++;
        if (m_resp !== {32'hD00D_0002, 1'b1}) begin errs++; $display("FAIL zero_wait_m_resp got %h exp %h", m_resp, {32'hD00D_0002, 1'b1}); end
        advance();
        m_req = req(1'b1, 32'h0000_0040, 32'h5, 4'h1);
        settle();
        vectors++;
        if (s_req !== exp_sreq || m_resp !== exp_resp) begin errs++; $display("FAIL zero_wait_next s_req %h m_resp %h exp %h %h", s_req, m_resp, exp_sreq, exp_resp); end
        advance();
        m_req = '0;
    endtask

    task automatic test_wait_states();
        m_req = req(1'b1, 32'h4000_0000, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) s_resp[i*RS +: RS] = {32'($urandom), 1'($urandom_range(0, 1))};
        s_resp[1*RS +: RS] = '0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) m_req = req(1'b1, 32'hC000_0000, 32'h0, 4'h0);
            if (c == 3) s_resp[1*RS +: RS] = {32'h1234_5678, 1'b1};
            settle();
            vectors++;
            if (s_req !== exp_sreq || m_resp !== exp_resp) begin errs++; $display("FAIL wait_cycle%0d s_req %h m_resp %h exp %h %h", c, s_req, m_resp, exp_sreq, exp_resp); end
            vectors++;
            if (s_req[2*RQ-1] !== 1'b1 || s_req[4*RQ-1] !== 1'b0) begin errs++; $display("FAIL wait_route%0d valid1 %b valid3 %b exp 1 0", c, s_req[2*RQ-1], s_req[4*RQ-1]); end
            if (c == 3) begin
                vectors++;
                if (m_resp !== {32'h1234_5678, 1'b1}) begin errs++; $display("FAIL wait_rdata got %h exp %h", m_resp, {32'h1234_5678, 1'b1}); end
            end
            advance();
        end
        s_resp[3*RS +: RS] = {32'h3333_3333, 1'b1};
        settle();
        vectors++;
        if (s_req[4*RQ-1] !== 1'b1 || m_resp !== {32'h3333_3333, 1'b1}) begin errs++; $display("FAIL wait_idle_after valid3 %b m_resp %h exp 1 %h", s_req[4*RQ-1], m_resp, {32'h3333_3333, 1'b1}); end
        advance();
        m_req = '0;
    endtask

    task automatic test_spurious();
        m_req = req(1'b1, 32'h0000_1000, 32'h0, 4'h0);
        s_resp = '0;
        s_resp[3*RS +: RS] = {32'hFFFF_FFFF, 1'b1};
        for (int c = 0; c < 4; c++) begin
            if (c == 3) s_resp[0 +: RS] = {32'h0BAD_F00D, 1'b1};
            settle();
            vectors++;
            if (m_resp !== exp_resp) begin errs++; $display("FAIL spurious_cycle%0d m_resp got %h exp %h", c, m_resp, exp_resp); end
            vectors++;
            if (m_resp[0] !== (c == 3)) begin errs++; $display("FAIL spurious_ready%0d got %b exp %b", c, m_resp[0], c == 3); end
            advance();
        end
        m_req = '0;
    endtask

    task automatic test_back_to_back();
        m_req = req(1'b1, 32'h0000_0004, 32'hAA, 4'h1);
        s_resp = '0;
        settle();
        advance();
        s_resp[0 +: RS] = {32'h0000_00AA, 1'b1};
        settle();
        vectors++;
        if (m_resp !== {32'h0000_00AA, 1'b1}) begin errs++; $display("FAIL b2b_complete got %h exp %h", m_resp, {32'h0000_00AA, 1'b1}); end
        advance();
        m_req = req(1'b1, 32'hC000_0100, 32'hBB, 4'h3);
        settle();
        vectors++;
        if (s_req[4*RQ-1] !== 1'b1 || s_req[RQ-1] !== 1'b0) begin errs++; $display("FAIL b2b_route valid3 %b valid0 %b exp 1 0", s_req[4*RQ-1], s_req[RQ-1]); end
        vectors++;
        if (s_req !== exp_sreq || m_resp !== exp_resp) begin errs++; $display("FAIL b2b_model s_req %h m_resp %h exp %h %h", s_req, m_resp, exp_sreq, exp_resp); end
        advance();
        s_resp[3*RS +: RS] = {32'h0000_00BB, 1'b1};
        settle();
        vectors++;
        if (m_resp !== {32'h0000_00BB, 1'b1}) begin errs++; $display("FAIL b2b_second got %h exp %h", m_resp, {32'h0000_00BB, 1'b1}); end
        advance();
        m_req = '0; s_resp = '0;
    endtask

    task automatic test_abort();
        m_req = req(1'b1, 32'h8000_0000, 32'h1, 4'h1);
        s_resp = '0;
        settle();
        advance();
        m_req = req(1'b0, 32'h8000_0000, 32'h1, 4'h1);
        s_resp[2*RS +: RS] = {32'h2222_2222, 1'b1};
        settle();
        vectors++;
        if (s_req !== '0 || m_resp !== '0) begin errs++; $display("FAIL abort_zero s_req %h m_resp %h exp 0", s_req, m_resp); end
        advance();
        m_req = req(1'b1, 32'h4000_0008, 32'h2, 4'h2);
        s_resp[1*RS +: RS] = {32'h1111_1111, 1'b1};
        settle();
        vectors++;
        if (s_req[2*RQ-1] !== 1'b1 || m_resp !== {32'h1111_1111, 1'b1}) begin errs++; $display("FAIL abort_fresh valid1 %b m_resp %h exp 1 %h", s_req[2*RQ-1], m_resp, {32'h1111_1111, 1'b1}); end
        advance();
        m_req = '0; s_resp = '0;
    endtask

    task automatic test_reset_busy();
        m_req = req(1'b1, 32'h8000_0000, 32'h9, 4'h1);
        s_resp = '0;
        settle();
        advance();
        rst = 1'b1;
        s_resp[2*RS +: RS] = {32'h2222_2222, 1'b1};
        settle();
        vectors++;
        if (m_resp !== '0) begin errs++; $display("FAIL reset_busy_m_resp got %h exp 0", m_resp); end
        advance();
        rst = 1'b0;
        m_req = req(1'b1, 32'h4000_0000, 32'h7, 4'h1);
        s_resp[1*RS +: RS] = {32'h1111_0000, 1'b1};
        settle();
        vectors++;
        if (s_req !== exp_sreq || m_resp !== {32'h1111_0000, 1'b1}) begin errs++; $display("FAIL reset_busy_next s_req %h m_resp %h exp %h %h", s_req, m_resp, exp_sreq, {32'h1111_0000, 1'b1}); end
        advance();
        m_req = '0; s_resp = '0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            m_req = req($urandom_range(0, 3) != 0, $urandom, $urandom, 4'($urandom));
            for (int i = 0; i < 4; i++) s_resp[i*RS +: RS] = {32'($urandom), $urandom_range(0, 2) == 0};
            settle();
            vectors++;
            if (s_req !== exp_sreq || m_resp !== exp_resp) begin errs++; $display("FAIL random%0d s_req %h m_resp %h exp %h %h", n, s_req, m_resp, exp_sreq, exp_resp); end
            advance();
        end
        m_req = '0; s_resp = '0;
        settle();
        advance();
    endtask

    task automatic test_unmapped();
        logic [3*RQ-1:0] e3;
        m_req3 = req(1'b1, 32'hC000_0000, 32'h55, 4'hF);
        s_resp3 = {{32'hA5A5_0002, 1'b1}, {32'hA5A5_0001, 1'b1}, {32'hA5A5_0000, 1'b1}};
        settle();
`ifdef SYNC_SPLIT_ERR_EN
        vectors++;
        if (s_req3 !== '0 || m_resp3 !== '0) begin errs++; $display("FAIL unmapped_first s_req3 %h m_resp3 %h exp 0 0", s_req3, m_resp3); end
        advance();
        settle();
        vectors++;
        if (s_req3 !== '0 || m_resp3 !== {32'h0, 1'b1}) begin errs++; $display("FAIL unmapped_err s_req3 %h m_resp3 %h exp 0 %h", s_req3, m_resp3, {32'h0, 1'b1}); end
        vectors++;
        if (err3 !== 1'b1) begin errs++; $display("FAIL unmapped_err_o got %b exp 1", err3); end
        advance();
        m_req3 = '0;
        settle();
        vectors++;
        if (m_resp3 !== '0 || err3 !== 1'b1) begin errs++; $display("FAIL unmapped_after m_resp3 %h err_o %b exp 0 1", m_resp3, err3); end
        vectors++;
        if (err4 !== 1'b0) begin errs++; $display("FAIL err_o_mapped got %b exp 0", err4); end
`else
        e3 = '0;
        e3[2*RQ +: RQ] = m_req3;
        vectors++;
        if (s_req3 !== e3) begin errs++; $display("FAIL unmapped_route s_req3 %h exp %h", s_req3, e3); end
        vectors++;
        if (m_resp3 !== {32'hA5A5_0002, 1'b1}) begin errs++; $display("FAIL unmapped_resp got %h exp %h", m_resp3, {32'hA5A5_0002, 1'b1}); end
`endif
        advance();
        m_req3 = '0; s_resp3 = '0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_spurious();
        test_back_to_back();
        test_abort();
        test_reset_busy();
        test_random();
        test_unmapped();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
